// File: rtl/i2s_tdm_playback_unit.sv
// rtl/i2s_tdm_playback_unit.sv - I2S / left-justified / TDM playback serializer with test ramp and underrun counting
module i2s_tdm_playback_unit #(
    parameter int NUM_CHANNELS = 2,
    parameter int SAMPLE_WIDTH = 24,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 4
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 enable,
    input  logic                                 justification,
    input  logic                                 test_mode,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] s_tdata,
    input  logic                                 s_tvalid,
    output logic                                 s_tready,
    output logic                                 ac_bclk,
    output logic                                 ac_pblrc,
    output logic                                 ac_pbdat,
    output logic                                 frame_start,
    output logic                                 underrun,
    output logic [15:0]                          underrun_count
);

    localparam int FRAME_W    = NUM_CHANNELS * SAMPLE_WIDTH;
    localparam int FRAME_BITS = NUM_CHANNELS * SLOT_WIDTH;
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam int DIV_W      = $clog2(BCLK_DIV);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                  state;
    logic [DIV_W-1:0]        div_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [FRAME_W-1:0]      holding;
    logic                    holding_full;
    logic [FRAME_W-1:0]      shift_frame;
    logic [SAMPLE_WIDTH-1:0] frame_count;

    logic                    div_wrap;
    logic                    last_bit;
    logic                    go_idle;
    logic                    frame_edge;
    logic                    consume;
    logic                    accept;
    logic                    hf_next;
    logic [DIV_W-1:0]        div_next;
    logic [BIT_W-1:0]        bit_next;
    logic [FRAME_W-1:0]      ramp_frame;
    logic [FRAME_W-1:0]      load_frame;
    logic [FRAME_W-1:0]      frame_next;

    // Serial bit for a frame position; I2S delays each slot's MSB by one bclk.
    function automatic logic serial_bit(input logic [FRAME_W-1:0] frame,
                                        input logic [BIT_W-1:0]   idx,
                                        input logic               lj);
        int                 slot;
        int                 pos;
        int                 sel;
        logic [FRAME_W-1:0] shifted;
        serial_bit = 1'b0;
        shifted    = '0;
        slot       = int'(idx) / SLOT_WIDTH;
        pos        = int'(idx) % SLOT_WIDTH;
        sel        = lj ? pos : pos - 1;
        if (sel >= 0 && sel < SAMPLE_WIDTH) begin
            shifted    = frame >> (slot * SAMPLE_WIDTH + SAMPLE_WIDTH - 1 - sel);
            serial_bit = shifted[0];
        end
    endfunction

    function automatic logic frame_clock(input logic [BIT_W-1:0] idx);
        if (NUM_CHANNELS == 2) begin
            frame_clock = (int'(idx) >= SLOT_WIDTH);
        end else begin
            frame_clock = (idx == '0);
        end
    endfunction

    always_comb begin
        ramp_frame = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            ramp_frame[c*SAMPLE_WIDTH +: SAMPLE_WIDTH] = frame_count + SAMPLE_WIDTH'(c);
        end
    end

    always_comb begin
        div_wrap   = (div_cnt == DIV_W'(BCLK_DIV - 1));
        last_bit   = (bit_cnt == BIT_W'(FRAME_BITS - 1));
        div_next   = '0;
        bit_next   = '0;
        go_idle    = 1'b0;
        frame_edge = 1'b0;
        case (state)
            ST_IDLE: begin
                go_idle    = !enable;
                frame_edge = enable;
            end
            ST_RUN: begin
                div_next   = div_wrap ? '0 : div_cnt + 1'b1;
                bit_next   = bit_cnt;
                if (div_wrap) begin
                    bit_next = last_bit ? '0 : bit_cnt + 1'b1;
                end
                go_idle    = div_wrap && last_bit && !enable;
                frame_edge = div_wrap && last_bit && enable;
            end
            default: go_idle = 1'b1;
        endcase

        if (test_mode) begin
            load_frame = ramp_frame;
        end else if (holding_full) begin
            load_frame = holding;
        end else begin
            load_frame = '0;
        end
        frame_next = frame_edge ? load_frame : shift_frame;

        // s_tready is only high while the holding register is empty, so a
        // consume and an accept can never coincide.
        accept  = s_tvalid && s_tready;
        consume = frame_edge && !test_mode && holding_full;
        hf_next = holding_full;
        if (consume) begin
            hf_next = 1'b0;
        end else if (accept) begin
            hf_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= ST_IDLE;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            holding        <= '0;
            holding_full   <= 1'b0;
            shift_frame    <= '0;
            frame_count    <= '0;
            s_tready       <= 1'b0;
            ac_bclk        <= 1'b0;
            ac_pblrc       <= 1'b0;
            ac_pbdat       <= 1'b0;
            frame_start    <= 1'b0;
            underrun       <= 1'b0;
            underrun_count <= '0;
        end else begin
            frame_start  <= 1'b0;
            underrun     <= 1'b0;
            holding_full <= hf_next;
            s_tready     <= !hf_next && !test_mode;
            shift_frame  <= frame_next;
            if (accept) begin
                holding <= s_tdata;
            end

            if (go_idle) begin
                state    <= ST_IDLE;
                div_cnt  <= '0;
                bit_cnt  <= '0;
                ac_bclk  <= 1'b0;
                ac_pblrc <= 1'b0;
                ac_pbdat <= 1'b0;
            end else begin
                state    <= ST_RUN;
                div_cnt  <= div_next;
                bit_cnt  <= bit_next;
                ac_bclk  <= (int'(div_next) >= BCLK_DIV / 2);
                ac_pblrc <= frame_clock(bit_next);
                ac_pbdat <= serial_bit(frame_next, bit_next, justification);
            end

            if (frame_edge) begin
                frame_start <= 1'b1;
                if (test_mode) begin
                    frame_count <= frame_count + 1'b1;
                end else if (!holding_full) begin
                    underrun <= 1'b1;
                    if (underrun_count != 16'hFFFF) begin
                        underrun_count <= underrun_count + 16'd1;
                    end
                end
            end
        end
    end

endmodule
